circle_plotter: RTL and testbench

Parametrised pixel-stream circle renderer sitting between control logic and the `vga_adapter` write port (x, y, colour, plot). On a start handshake it optionally clears the frame to a background colour. It then draws a circle of run-time centre, radius and colour, either as an outline or filled, using the midpoint algorithm. Off-screen pixels are clipped, and completion is reported with busy/done.

---
 rtl/circle_plotter_if.sv | 38 +++
 rtl/circle_plotter.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_circle_plotter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/circle_plotter_if.sv
// circle_plotter_if: request operands and pixel write port of the circle plotter.
// Latency: none, wires only.
// Backpressure: none; the pixel sink must accept one pixel per cycle.
// Signals: start/cx/cy/radius/fg_colour/bg_colour/clear_en/fill_en (request),
//          x/y/colour/plot (pixel write), busy/done (status).
interface circle_plotter_if #(
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int RW = 7,
  parameter int CW = 3
) ();
  logic          start;
  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  logic [RW-1:0] radius;
  logic [CW-1:0] fg_colour;
  logic [CW-1:0] bg_colour;
  logic          clear_en;
  logic          fill_en;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [CW-1:0] colour;
  logic          plot;
  logic          busy;
  logic          done;

  // Control side: issues requests, consumes pixels and status.
  modport master (
    output start, cx, cy, radius, fg_colour, bg_colour, clear_en, fill_en,
    input  x, y, colour, plot, busy, done
  );

  // Plotter side.
  modport slave (
    input  start, cx, cy, radius, fg_colour, bg_colour, clear_en, fill_en,
    output x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/circle_plotter.sv
// circle_plotter: optional frame clear, then midpoint circle (outline or filled) with clipping.
// Latency: start at edge 0 -> INIT in cycle 1 -> first candidate in cycle 2; done is a 1-cycle pulse.
// Backpressure: none; one candidate pixel per cycle, start is only sampled in IDLE.
// Ports: clock, resetn (async, active-low); bus (slave modport) carries the request
//        operands in and the pixel write port x/y/colour/plot plus busy/done out.
module circle_plotter #(
  parameter int SCREEN_WIDTH  = 160,
  parameter int SCREEN_HEIGHT = 120,
  parameter int XW            = 8,
  parameter int YW            = 7,
  parameter int RW            = 7,
  parameter int CW            = 3
) (
  input  logic            clock,
  input  logic            resetn,
  circle_plotter_if.slave bus
);

  localparam int XSW = XW + 2;   // signed x arithmetic
  localparam int YSW = YW + 2;   // signed y arithmetic
  localparam int OW  = RW + 2;   // ox/oy: room for oy = radius+1 and ox = -1
  localparam int CRW = RW + 3;   // decision variable

  localparam logic signed [OW-1:0]  ONE_O      = OW'(1);
  localparam logic signed [CRW-1:0] ONE_C      = CRW'(1);
  localparam logic signed [XSW-1:0] ONE_X      = XSW'(1);
  localparam logic signed [XSW-1:0] SW_S       = XSW'(SCREEN_WIDTH);
  localparam logic signed [YSW-1:0] SH_S       = YSW'(SCREEN_HEIGHT);
  localparam logic [XW-1:0]         CLR_X_LAST = XW'(SCREEN_WIDTH - 1);
  localparam logic [YW-1:0]         CLR_Y_LAST = YW'(SCREEN_HEIGHT - 1);
  localparam logic [XW-1:0]         ONE_XU     = XW'(1);
  localparam logic [YW-1:0]         ONE_YU     = YW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_INIT  = 3'd2,
    S_OCT   = 3'd3,
    S_SPAN  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                r_state,  w_state_n;
  logic [XW-1:0]         r_cx,     w_cx_n;
  logic [YW-1:0]         r_cy,     w_cy_n;
  logic [RW-1:0]         r_radius, w_radius_n;
  logic [CW-1:0]         r_fg,     w_fg_n;
  logic [CW-1:0]         r_bg,     w_bg_n;
  logic                  r_fill,   w_fill_n;
  logic signed [OW-1:0]  r_ox,     w_ox_n;
  logic signed [OW-1:0]  r_oy,     w_oy_n;
  logic signed [CRW-1:0] r_crit,   w_crit_n;
  logic [2:0]            r_k,      w_k_n;
  logic [1:0]            r_span,   w_span_n;
  logic signed [XSW-1:0] r_off,    w_off_n;   // x offset from cx within a span
  logic [XW-1:0]         r_clr_x,  w_clr_x_n;
  logic [YW-1:0]         r_clr_y,  w_clr_y_n;

  // ---------------------------------------------------------------------------
  // Midpoint step update, shared by OCT (k=7) and SPAN (last pixel of span 3).
  // ---------------------------------------------------------------------------
  logic                  w_crit_le0;
  logic signed [OW-1:0]  w_oy_upd, w_ox_upd, w_rad_o;
  logic signed [CRW-1:0] w_oy_c, w_ox_c, w_crit_upd;
  logic                  w_finish;

  assign w_crit_le0 = r_crit[CRW-1] || (r_crit == '0);
  assign w_oy_upd   = r_oy + ONE_O;
  assign w_ox_upd   = w_crit_le0 ? r_ox : (r_ox - ONE_O);
  assign w_oy_c     = CRW'(w_oy_upd);
  assign w_ox_c     = CRW'(w_ox_upd);
  // Both branches use the already-updated oy/ox.
  assign w_crit_upd = w_crit_le0 ? (r_crit + (w_oy_c <<< 1) + ONE_C)
                                 : (r_crit + ((w_oy_c - w_ox_c) <<< 1) + ONE_C);
  assign w_finish   = (w_oy_upd > w_ox_upd);
  assign w_rad_o    = $signed({2'b00, r_radius});

  // ---------------------------------------------------------------------------
  // Candidate pixel decode from registered state.
  // ---------------------------------------------------------------------------
  logic signed [XSW-1:0] w_cx_s, w_ox_x, w_oy_x, w_dx, w_px, w_half_x;
  logic signed [YSW-1:0] w_cy_s, w_ox_y, w_oy_y, w_dy, w_py;
  logic                  w_on_screen;
  logic                  w_span_end;

  assign w_cx_s = $signed({2'b00, r_cx});
  assign w_cy_s = $signed({2'b00, r_cy});
  assign w_ox_x = XSW'(r_ox);
  assign w_oy_x = XSW'(r_oy);
  assign w_ox_y = YSW'(r_ox);
  assign w_oy_y = YSW'(r_oy);

  always_comb begin
    w_dx = '0;
    w_dy = '0;
    if (r_state == S_SPAN) begin
      w_dx = r_off;
      case (r_span)
        2'd0:    w_dy = w_oy_y;
        2'd1:    w_dy = -w_oy_y;
        2'd2:    w_dy = w_ox_y;
        default: w_dy = -w_ox_y;
      endcase
    end else begin
      // Odd k swaps the roles of ox and oy; k=2..5 mirror x; k=4..7 mirror y.
      w_dx = r_k[0] ? w_oy_x : w_ox_x;
      w_dy = r_k[0] ? w_ox_y : w_oy_y;
      if (r_k[2] ^ r_k[1]) w_dx = -w_dx;
      if (r_k[2])          w_dy = -w_dy;
    end
  end

  assign w_px        = w_cx_s + w_dx;
  assign w_py        = w_cy_s + w_dy;
  assign w_on_screen = !w_px[XSW-1] && (w_px < SW_S) && !w_py[YSW-1] && (w_py < SH_S);

  // Spans 0/1 run over +-ox, spans 2/3 over +-oy.
  assign w_half_x   = r_span[1] ? w_oy_x : w_ox_x;
  assign w_span_end = (r_off == w_half_x);

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_n  = r_state;
    w_cx_n     = r_cx;
    w_cy_n     = r_cy;
    w_radius_n = r_radius;
    w_fg_n     = r_fg;
    w_bg_n     = r_bg;
    w_fill_n   = r_fill;
    w_ox_n     = r_ox;
    w_oy_n     = r_oy;
    w_crit_n   = r_crit;
    w_k_n      = r_k;
    w_span_n   = r_span;
    w_off_n    = r_off;
    w_clr_x_n  = r_clr_x;
    w_clr_y_n  = r_clr_y;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_cx_n     = bus.cx;
          w_cy_n     = bus.cy;
          w_radius_n = bus.radius;
          w_fg_n     = bus.fg_colour;
          w_bg_n     = bus.bg_colour;
          w_fill_n   = bus.fill_en;
          w_clr_x_n  = '0;
          w_clr_y_n  = '0;
          w_state_n  = bus.clear_en ? S_CLEAR : S_INIT;
        end
      end

      S_CLEAR: begin
        if (r_clr_x == CLR_X_LAST) begin
          w_clr_x_n = '0;
          if (r_clr_y == CLR_Y_LAST) begin
            w_clr_y_n = '0;
            w_state_n = S_INIT;
          end else begin
            w_clr_y_n = r_clr_y + ONE_YU;
          end
        end else begin
          w_clr_x_n = r_clr_x + ONE_XU;
        end
      end

      S_INIT: begin
        w_ox_n    = w_rad_o;
        w_oy_n    = '0;
        w_crit_n  = ONE_C - $signed({3'b000, r_radius});
        w_k_n     = '0;
        w_span_n  = '0;
        w_off_n   = -(XSW'(w_rad_o));
        w_state_n = r_fill ? S_SPAN : S_OCT;
      end

      S_OCT: begin
        w_k_n = r_k + 3'd1;
        if (r_k == 3'd7) begin
          w_ox_n   = w_ox_upd;
          w_oy_n   = w_oy_upd;
          w_crit_n = w_crit_upd;
          if (w_finish) w_state_n = S_DONE;
        end
      end

      S_SPAN: begin
        if (w_span_end) begin
          if (r_span == 2'd3) begin
            w_ox_n   = w_ox_upd;
            w_oy_n   = w_oy_upd;
            w_crit_n = w_crit_upd;
            w_span_n = '0;
            w_off_n  = -(XSW'(w_ox_upd));
            if (w_finish) w_state_n = S_DONE;
          end else begin
            w_span_n = r_span + 2'd1;
            // Span 1 keeps the ox half-width; spans 2 and 3 use oy.
            w_off_n  = (r_span == 2'd0) ? -w_ox_x : -w_oy_x;
          end
        end else begin
          w_off_n = r_off + ONE_X;
        end
      end

      S_DONE: begin
        w_k_n     = '0;
        w_span_n  = '0;
        w_off_n   = '0;
        w_state_n = S_IDLE;
      end

      default: w_state_n = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode: registered state only, nothing from the request inputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.x      = '0;
    bus.y      = '0;
    bus.colour = '0;
    bus.plot   = 1'b0;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (r_state)
      S_CLEAR: begin
        bus.x      = r_clr_x;
        bus.y      = r_clr_y;
        bus.colour = r_bg;
        bus.plot   = 1'b1;
        bus.busy   = 1'b1;
      end
      S_INIT: begin
        bus.busy = 1'b1;
      end
      S_OCT, S_SPAN: begin
        bus.x      = w_px[XW-1:0];
        bus.y      = w_py[YW-1:0];
        bus.colour = r_fg;
        bus.plot   = w_on_screen;
        bus.busy   = 1'b1;
      end
      S_DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_cx     <= '0;
      r_cy     <= '0;
      r_radius <= '0;
      r_fg     <= '0;
      r_bg     <= '0;
      r_fill   <= 1'b0;
      r_ox     <= '0;
      r_oy     <= '0;
      r_crit   <= '0;
      r_k      <= '0;
      r_span   <= '0;
      r_off    <= '0;
      r_clr_x  <= '0;
      r_clr_y  <= '0;
    end else begin
      r_state  <= w_state_n;
      r_cx     <= w_cx_n;
      r_cy     <= w_cy_n;
      r_radius <= w_radius_n;
      r_fg     <= w_fg_n;
      r_bg     <= w_bg_n;
      r_fill   <= w_fill_n;
      r_ox     <= w_ox_n;
      r_oy     <= w_oy_n;
      r_crit   <= w_crit_n;
      r_k      <= w_k_n;
      r_span   <= w_span_n;
      r_off    <= w_off_n;
      r_clr_x  <= w_clr_x_n;
      r_clr_y  <= w_clr_y_n;
    end
  end

endmodule

// File: tb/tb_circle_plotter.sv
// tb_circle_plotter: directed checks of circle_plotter against hand-computed pixel sequences.
// Latency: cycle 1 follows the start edge; samples are taken on the falling edge.
// Backpressure: none; the bench records every cycle of an operation.
module tb_circle_plotter;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  // Per-cycle capture of one operation; index = cycle number after the start edge.
  int q_plot[$], q_x[$], q_y[$], q_col[$], q_busy[$];
  int done_cyc;
  int after_busy;

  // Outline radius 1 at (80,60): two steps of eight candidates.
  int e1x [16] = '{81, 80, 79, 80, 79, 80, 81, 80, 81, 81, 79, 79, 79, 79, 81, 81};
  int e1y [16] = '{60, 61, 60, 61, 60, 59, 60, 59, 61, 61, 61, 61, 59, 59, 59, 59};
  // Filled radius 1 at (10,10): 8 pixels in step 1, 12 in step 2.
  int efx [20] = '{9, 10, 11, 9, 10, 11, 10, 10,
                   9, 10, 11, 9, 10, 11, 9, 10, 11, 9, 10, 11};
  int efy [20] = '{10, 10, 10, 10, 10, 10, 11, 9,
                   11, 11, 11, 9, 9, 9, 11, 11, 11, 9, 9, 9};

  circle_plotter_if bus ();

  circle_plotter dut (
    .clock  (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int plots_total();
    int n = 0;
    foreach (q_plot[i]) n += q_plot[i];
    return n;
  endfunction

  // Issue one request, scramble the operand inputs afterwards, and capture
  // every cycle up to and including the done pulse, plus the cycle after it.
  task automatic go(input int gcx, input int gcy, input int grad, input int gfg,
                    input int gbg, input int gclr, input int gfill, input int budget);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.cx        = 8'(gcx);
    bus.cy        = 7'(gcy);
    bus.radius    = 7'(grad);
    bus.fg_colour = 3'(gfg);
    bus.bg_colour = 3'(gbg);
    bus.clear_en  = 1'(gclr);
    bus.fill_en   = 1'(gfill);
    @(negedge clk);
    bus.start     = 1'b0;
    bus.cx        = 8'd0;
    bus.cy        = 7'd0;
    bus.radius    = 7'd0;
    bus.fg_colour = 3'd0;
    bus.bg_colour = 3'd7;
    bus.clear_en  = 1'b1;
    bus.fill_en   = ~bus.fill_en;
    q_plot.delete(); q_x.delete(); q_y.delete(); q_col.delete(); q_busy.delete();
    q_plot.push_back(0); q_x.push_back(0); q_y.push_back(0);
    q_col.push_back(0);  q_busy.push_back(0);
    done_cyc = -1;
    for (int c = 1; c <= budget; c++) begin
      q_plot.push_back(int'(bus.plot));
      q_x.push_back(int'(bus.x));
      q_y.push_back(int'(bus.y));
      q_col.push_back(int'(bus.colour));
      q_busy.push_back(int'(bus.busy));
      if (bus.done === 1'b1) begin
        done_cyc = c;
        break;
      end
      @(negedge clk);
    end
    chk("done_seen", int'(done_cyc > 0), 1);
    @(negedge clk);
    after_busy = int'(bus.busy);
    bus.clear_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nbad;
    int hit [3][3];
    int dq[$];
    int b11, b12, p12;

    bus.start = 1'b0; bus.cx = '0; bus.cy = '0; bus.radius = '0;
    bus.fg_colour = '0; bus.bg_colour = '0; bus.clear_en = 1'b0; bus.fill_en = 1'b0;

    // Reset state.
    #2;
    chk("rst_x", int'(bus.x), 0);
    chk("rst_y", int'(bus.y), 0);
    chk("rst_colour", int'(bus.colour), 0);
    chk("rst_plot", int'(bus.plot), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    @(negedge clk);
    resetn = 1'b1;

    // Outline, radius 0 at (80,60).
    go(80, 60, 0, 3, 0, 0, 0, 100);
    chk("r0_done_cyc", done_cyc, 10);
    chk("r0_after_busy", after_busy, 0);
    chk("r0_init_plot", q_plot[1], 0);
    chk("r0_init_busy", q_busy[1], 1);
    chk("r0_done_busy", q_busy[10], 1);
    chk("r0_plots", plots_total(), 8);
    nbad = 0;
    for (int c = 2; c <= 9; c++)
      if (q_plot[c] != 1 || q_x[c] != 80 || q_y[c] != 60 || q_col[c] != 3) nbad++;
    chk("r0_pix_bad", nbad, 0);

    // Outline, radius 1 at (80,60).
    go(80, 60, 1, 6, 0, 0, 0, 100);
    chk("r1_done_cyc", done_cyc, 18);
    chk("r1_plots", plots_total(), 16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("r1_x%0d", i), q_x[i+2], e1x[i]);
      chk($sformatf("r1_y%0d", i), q_y[i+2], e1y[i]);
    end

    // Clear to colour 0, then radius 0 at (0,0) in colour 5.
    go(0, 0, 0, 5, 0, 1, 0, 20000);
    chk("clr_done_cyc", done_cyc, 19210);
    chk("clr_first_x", q_x[1], 0);
    chk("clr_first_y", q_y[1], 0);
    chk("clr_last_x", q_x[19200], 159);
    chk("clr_last_y", q_y[19200], 119);
    chk("clr_row1_x", q_x[161], 0);
    chk("clr_row1_y", q_y[161], 1);
    nbad = 0;
    for (int c = 1; c <= 19200; c++)
      if (q_plot[c] != 1 || q_col[c] != 0 || q_x[c] != (c - 1) % 160 || q_y[c] != (c - 1) / 160)
        nbad++;
    chk("clr_raster_bad", nbad, 0);
    chk("clr_init_plot", q_plot[19201], 0);
    nbad = 0;
    for (int c = 19202; c <= 19209; c++)
      if (q_plot[c] != 1 || q_x[c] != 0 || q_y[c] != 0 || q_col[c] != 5) nbad++;
    chk("clr_circle_bad", nbad, 0);
    chk("clr_plots", plots_total(), 19208);

    // Clipping, radius 5 at (2,2).
    go(2, 2, 5, 1, 0, 0, 0, 200);
    chk("clip_done_cyc", done_cyc, 34);
    chk("clip_k0_plot", q_plot[2], 1);
    chk("clip_k0_x", q_x[2], 7);
    chk("clip_k2_plot", q_plot[4], 0);
    chk("clip_k2_busy", q_busy[4], 1);
    chk("clip_plots", plots_total(), 14);
    nbad = 0;
    foreach (q_plot[c])
      if (q_plot[c] == 1 && (q_x[c] >= 160 || q_y[c] >= 120)) nbad++;
    chk("clip_offscreen", nbad, 0);

    // Filled, radius 1 at (10,10).
    go(10, 10, 1, 2, 0, 0, 1, 100);
    chk("fill_done_cyc", done_cyc, 22);
    chk("fill_plots", plots_total(), 20);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("fill_x%0d", i), q_x[i+2], efx[i]);
      chk($sformatf("fill_y%0d", i), q_y[i+2], efy[i]);
    end
    foreach (hit[i, j]) hit[i][j] = 0;
    for (int c = 2; c <= 21; c++)
      if (q_plot[c] == 1 && q_x[c] >= 9 && q_x[c] <= 11 && q_y[c] >= 9 && q_y[c] <= 11)
        hit[q_y[c]-9][q_x[c]-9] = 1;
    nbad = 0;
    foreach (hit[i, j]) if (hit[i][j] == 0) nbad++;
    chk("fill_block_missing", nbad, 0);

    // Asynchronous reset during OCT, then restart.
    @(negedge clk);
    bus.start = 1'b1; bus.cx = 8'd80; bus.cy = 7'd60; bus.radius = 7'd5;
    bus.fg_colour = 3'd4; bus.clear_en = 1'b0; bus.fill_en = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("arst_pre_plot", int'(bus.plot), 1);
    #1 resetn = 1'b0;
    #1;
    chk("arst_plot", int'(bus.plot), 0);
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_done", int'(bus.done), 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("arst_idle_busy", int'(bus.busy), 0);
    go(80, 60, 5, 4, 0, 0, 0, 200);
    chk("arst_done_cyc", done_cyc, 34);
    chk("arst_init_busy", q_busy[1], 1);
    chk("arst_init_plot", q_plot[1], 0);
    chk("arst_first_plot", q_plot[2], 1);
    chk("arst_first_x", q_x[2], 85);
    chk("arst_first_y", q_y[2], 60);
    chk("arst_first_col", q_col[2], 4);

    // start held high across DONE retriggers only from IDLE.
    @(negedge clk);
    bus.start = 1'b1; bus.cx = 8'd80; bus.cy = 7'd60; bus.radius = 7'd0;
    bus.fg_colour = 3'd1; bus.clear_en = 1'b0; bus.fill_en = 1'b0;
    b11 = -1; b12 = -1; p12 = -1;
    dq.delete();
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dq.push_back(c);
      if (c == 11) b11 = int'(bus.busy);
      if (c == 12) begin
        b12 = int'(bus.busy);
        p12 = int'(bus.plot);
        bus.start = 1'b0;
      end
    end
    chk("hold_done_count", dq.size(), 2);
    chk("hold_done1", (dq.size() > 0) ? dq[0] : -1, 10);
    chk("hold_done2", (dq.size() > 1) ? dq[1] : -1, 21);
    chk("hold_busy_c11", b11, 0);
    chk("hold_busy_c12", b12, 1);
    chk("hold_plot_c12", p12, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
